// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Latency: none (package).
// Backpressure: none (package).
// Contents: access-size encodings, responder FSM states, wait-counter width.
package dmem_pkg;

  // Access size encodings carried on req_size. The fourth code (2'b11) is
  // reserved and behaves as a word access.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The wait counter covers WAIT_CYCLES in the range 0..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane logic for one data-memory access: enables, store merge, load extract.
// Latency: purely combinational.
// Backpressure: none; evaluated on the latched request every cycle.
// Ports: addr_lo/size select lanes; wdata is right-justified store data;
//   word_in is the current memory word; word_out is the merged word to write;
//   load_data is the zero-extended load result; byte_en marks written lanes
//   (all zero when the access is misaligned); misaligned flags a bad offset.
// Build option DMEM_ALIGN_CHECK_EN: when defined, misaligned half/word accesses
//   are flagged and suppressed; otherwise the offset is forced to alignment.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] word_in,
  output logic [3:0]  byte_en,
  output logic [31:0] word_out,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  off;
  logic [31:0] wdata_sh;
  logic [31:0] word_sh;

  always_comb begin
    misaligned = 1'b0;
    off        = addr_lo;
`ifdef DMEM_ALIGN_CHECK_EN
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      default: misaligned = (addr_lo != 2'b00);
    endcase
`else
    // Without the check, drop the low offset bits the size cannot use.
    case (size)
      SZ_BYTE: off = addr_lo;
      SZ_HALF: off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
`endif

    case (size)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
    if (misaligned) byte_en = 4'b0000;

    // Move right-justified store data up to its lanes, then merge.
    wdata_sh = wdata << {off, 3'b000};
    word_out = word_in;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) word_out[8*i +: 8] = wdata_sh[8*i +: 8];
    end

    // Bring the addressed lanes down to bit 0 and zero-extend.
    word_sh = word_in >> {off, 3'b000};
    case (size)
      SZ_BYTE: load_data = {24'h0, word_sh[7:0]};
      SZ_HALF: load_data = {16'h0, word_sh[15:0]};
      default: load_data = word_sh;
    endcase
    if (misaligned) load_data = 32'h0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder behind the Mem-stage load/store port, with wait states.
// Latency: accept at edge T -> rsp_valid during cycle T+WAIT_CYCLES+2.
// Backpressure: req_ready only in IDLE; mem_stall freezes the pipe until RESP.
// Ports: clk/rst (sync, active high); req_valid/req_we/req_addr/req_wdata/
//   req_size request; req_ready accept; rsp_valid one-cycle pulse with
//   rsp_rdata (zero-extended load data, 0 for stores) and rsp_err; mem_stall.
// Build option DMEM_ALIGN_CHECK_EN enables misalignment detection (rsp_err);
//   without it rsp_err stays 0 and accesses are forced to aligned lanes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2    // 0..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_stall
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              accept;

  logic              we_q;
  logic [AW-1:0]     addr_q;     // only the bits that index storage are kept
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       word_rd;
  logic [3:0]        byte_en;
  logic [31:0]       word_wr;
  logic [31:0]       load_data;
  logic              misaligned;

  // Address bits above the storage range alias and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  assign word_rd = mem[addr_q[AW-1:2]];

  dmem_lane_unit u_lane (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .wdata      (wdata_q),
    .word_in    (word_rd),
    .byte_en    (byte_en),
    .word_out   (word_wr),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    accept    = 1'b0;
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    // Low in RESP so the pipeline advances on the response cycle.
    mem_stall = (req_valid && (state == ST_IDLE)) ||
                (state == ST_WAIT) || (state == ST_ACCESS);
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = ST_ACCESS;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nx = ST_ACCESS;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= SZ_BYTE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
        size_q  <= req_size;
      end
      if (state == ST_ACCESS) begin
        rsp_err   <= misaligned;
        rsp_rdata <= we_q ? 32'h0 : load_data;
        // Misaligned stores arrive with no byte enables and leave memory alone.
        if (we_q && (byte_en != 4'b0000)) mem[addr_q[AW-1:2]] <= word_wr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus random traffic
// checked against a byte-array reference model; a second zero-wait instance
// covers back-to-back requests with req_valid held high.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int W = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, rsp_valid, rsp_err, mem_stall;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [1:0]  b_req_size;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_stall;
  logic [31:0] b_rsp_rdata;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_stall(mem_stall)
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .mem_stall(b_mem_stall)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: 4 KiB of bytes, address taken modulo 4096.
  logic [7:0] ref_mem [4096];

  task automatic clear_model();
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
  endtask

  task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, output logic [31:0] rdata, output logic err);
    int nb;
    logic [1:0] off;
    nb    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off   = addr[1:0];
    err   = 1'b0;
    rdata = 32'h0;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((int'(off) % nb) != 0) err = 1'b1;
`else
    off = 2'(int'(off) / nb * nb);
`endif
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        if (we) ref_mem[int'({addr[11:2], off}) + i] = wdata[8*i +: 8];
        else    rdata[8*i +: 8] = ref_mem[int'({addr[11:2], off}) + i];
      end
    end
  endtask

  // One full transaction on the main instance; request lines carry junk while busy.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, output logic [31:0] got_rdata, output logic got_err);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          cyc;
    int          stall_bad;
    model_txn(we, addr, wdata, size, exp_rdata, exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
    #1;
    chk("accept_ready", 32'(req_ready), 1);
    chk("accept_stall", 32'(mem_stall), 1);
    @(posedge clk);
    stall_bad = 0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (rsp_valid) break;
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_size  = 2'($urandom_range(0, 3));
      #1;
      if (!mem_stall || req_ready) stall_bad++;
    end
    req_valid = 1'b0;
    #1;
    chk("latency", 32'(cyc), 32'(W + 2));
    chk("busy_stall_ready", 32'(stall_bad), 0);
    chk("resp_stall_low", 32'(mem_stall), 0);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          rsp_seen;
  logic [31:0] ra;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_size = '0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_stall", 32'(mem_stall), 0);

    // Word store then load.
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, rd, er);
    do_txn(1'b0, 32'h10, 32'h0, SZ_WORD, rd, er);
    chk("word_load_lit", rd, 32'hDEADBEEF);

    // Byte and halfword lanes.
    do_txn(1'b1, 32'h20, 32'h11223344, SZ_WORD, rd, er);
    do_txn(1'b1, 32'h21, 32'h000000AA, SZ_BYTE, rd, er);
    do_txn(1'b0, 32'h20, 32'h0, SZ_WORD, rd, er);
    chk("byte_merge_lit", rd, 32'h1122AA44);
    do_txn(1'b0, 32'h22, 32'h0, SZ_HALF, rd, er);
    chk("half_load_lit", rd, 32'h00001122);
    do_txn(1'b0, 32'h23, 32'h0, SZ_BYTE, rd, er);
    chk("byte_load_lit", rd, 32'h00000011);

    // Misaligned word store and half load.
    do_txn(1'b1, 32'h22, 32'hFFFFFFFF, SZ_WORD, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_store_err_lit", 32'(er), 1);
`else
    chk("mis_store_err_lit", 32'(er), 0);
`endif
    do_txn(1'b0, 32'h20, 32'h0, SZ_WORD, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_store_mem_lit", rd, 32'h1122AA44);
`else
    chk("mis_store_mem_lit", rd, 32'hFFFFFFFF);
`endif
    do_txn(1'b0, 32'h21, 32'h0, SZ_HALF, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_load_data_lit", rd, 32'h0);
    chk("mis_load_err_lit", 32'(er), 1);
`else
    chk("mis_load_data_lit", rd, 32'h0000FFFF);
    chk("mis_load_err_lit", 32'(er), 0);
`endif

    // Aliasing modulo 4 KiB.
    do_txn(1'b1, 32'h1000, 32'h5A5A5A5A, SZ_WORD, rd, er);
    do_txn(1'b0, 32'h0000, 32'h0, SZ_WORD, rd, er);
    chk("alias_lit", rd, 32'h5A5A5A5A);

    // Random traffic over a small window, half of it with junk upper bits.
    for (int n = 0; n < 40; n++) begin
      ra = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) ra = ra | ($urandom & 32'hFFFF_F000);
      do_txn(1'($urandom_range(0, 1)), ra, $urandom, 2'($urandom_range(0, 3)), rd, er);
    end

    // Reset during the WAIT phase of a store to 0x30.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_size = SZ_WORD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    #1;
    chk("midrst_ready", 32'(req_ready), 1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_rdata", rsp_rdata, 0);
    rsp_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    chk("midrst_no_rsp", 32'(rsp_seen), 0);
    do_txn(1'b0, 32'h30, 32'h0, SZ_WORD, rd, er);
    chk("midrst_mem_lit", rd, 32'h0);

    // Zero-wait instance: req_valid held high across two requests.
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'h12345678; b_req_size = SZ_WORD;
    #1;
    chk("b2b_ready_first", 32'(b_req_ready), 1);
    @(negedge clk);  // ACCESS
    b_req_we = 1'b1; b_req_addr = $urandom & 32'hC; b_req_wdata = $urandom; b_req_size = SZ_WORD;
    #1;
    chk("b2b_access_ready", 32'(b_req_ready), 0);
    chk("b2b_access_stall", 32'(b_mem_stall), 1);
    chk("b2b_access_rsp", 32'(b_rsp_valid), 0);
    @(negedge clk);  // RESP
    b_req_we = 1'b1; b_req_addr = $urandom & 32'hC; b_req_wdata = $urandom;
    #1;
    chk("b2b_resp_valid", 32'(b_rsp_valid), 1);
    chk("b2b_resp_stall", 32'(b_mem_stall), 0);
    chk("b2b_resp_ready", 32'(b_req_ready), 0);
    @(negedge clk);  // IDLE, three cycles after the first accept
    b_req_we = 1'b0; b_req_addr = 32'h8; b_req_wdata = 32'h0; b_req_size = SZ_WORD;
    #1;
    chk("b2b_ready_second", 32'(b_req_ready), 1);
    chk("b2b_idle_stall", 32'(b_mem_stall), 1);
    @(negedge clk);  // ACCESS
    b_req_we = 1'b1; b_req_addr = 32'h8; b_req_wdata = $urandom;
    #1;
    chk("b2b_access2_rsp", 32'(b_rsp_valid), 0);
    @(negedge clk);  // RESP
    b_req_valid = 1'b0;
    #1;
    chk("b2b_resp2_valid", 32'(b_rsp_valid), 1);
    chk("b2b_load_data", b_rsp_rdata, 32'h12345678);
    chk("b2b_load_err", 32'(b_rsp_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the Mem-stage load/store interface.
- Accepts one load or store request per transaction through a valid/ready handshake.
- Inserts a configurable number of wait states, then returns read data or a write acknowledge.
- Drives mem_stall so the pipeline freezes while a transaction is outstanding.
- Replaces the zero-latency single-cycle data memory.

Parameters:
- DEPTH_LOG2, 10: log2 of the word count. Word index is req_addr[DEPTH_LOG2+1:2].
- WAIT_CYCLES, 2: number of wait states between acceptance and access, range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- req_ready  out  1  responder can accept a request.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data, right-justified and zero-extended; 0 for stores.
- rsp_err  out  1  misaligned access flagged, valid with rsp_valid.
- mem_stall  out  1  pipeline freeze request.

Behaviour:
- Reset: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0, all memory words = 0. Reset applies on the clk edge where rst = 1 and overrides any in-flight transaction; no write completes in that cycle.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready = 1. On req_valid the responder latches we, addr, wdata and size.
  - WAIT_CYCLES > 0: go to WAIT and load the counter with WAIT_CYCLES-1.
  - WAIT_CYCLES = 0: go straight to ACCESS.
- WAIT: req_ready = 0. Counter decrements each cycle; at 0, go to ACCESS.
- ACCESS: one cycle.
  - Store: merge wdata into the addressed word using byte lanes selected by addr[1:0] and size, then write.
  - Load: read the word, extract the selected lanes, zero-extend into the registered rsp_rdata.
  - Go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle. rsp_rdata and rsp_err are held stable while rsp_valid = 1. Next state is IDLE; a new request can be accepted in the cycle after RESP.
- Latency: request accepted at edge T gives rsp_valid high in cycle T+WAIT_CYCLES+2.
- Throughput: one transaction per WAIT_CYCLES+3 cycles.
- mem_stall = (req_valid & state==IDLE) | (state==WAIT) | (state==ACCESS). It is low in RESP so the pipeline advances on the response cycle.
- Misalignment: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Store: suppressed, memory unchanged.
  - Load: rsp_rdata = 0.
  - rsp_err = 1 with the response.
- Address wrap: bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo 4·2^DEPTH_LOG2 bytes.
- Request inputs are ignored while the state is not IDLE.
- Lane ordering is little-endian: byte 0 = bits [7:0].

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: misalignment detection and rsp_err behave as specified above.
- Undefined:
  - rsp_err is tied to 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - The access completes on the forced-aligned lanes.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum;
  - width constants for the wait counter.
- Sub-module dmem_lane_unit (combinational) holds:
  - byte-enable generation;
  - store-data merge;
  - load-data extract and zero-extension;
  - misalignment detect.
- Keep the FSM, counter and storage in dmem_responder.

Test Plan:
- Word write then read, WAIT_CYCLES = 2: store 0xDEADBEEF at 0x10, then load 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0. rsp_valid appears exactly 4 cycles after each accept; mem_stall is high for the 3 cycles before rsp_valid.
- Byte/half lanes: word 0x11223344 at 0x20; store byte 0xAA at 0x21 -> word 0x1122AA44. Load half at 0x22 -> 0x00001122. Load byte at 0x23 -> 0x00000011.
- Misaligned, macro defined: store word 0xFFFFFFFF at 0x22 -> rsp_err = 1, word at 0x20 unchanged. Load half at 0x21 -> rsp_rdata = 0, rsp_err = 1. Macro undefined: the same store writes 0xFFFFFFFF into word 0x20, rsp_err = 0.
- Reset mid-transaction: assert rst in the WAIT cycle of a store to 0x30 -> next cycle state IDLE, req_ready = 1, rsp_valid never pulses, word 0x30 reads 0.
- Back-to-back requests, WAIT_CYCLES = 0: req_valid held high with two loads -> accepts 3 cycles apart; requests changed during WAIT/ACCESS/RESP are ignored.
- Address aliasing, DEPTH_LOG2 = 10: store 0x5A5A5A5A at 0x1000 -> load at 0x0000 returns 0x5A5A5A5A.
